// File: rtl/c1_bus_pkg.sv
// C1 CPU<->cache bus definitions shared by the CPU-side master and its helpers.
// Command codes, master state encoding and command classification functions.
package c1_bus_pkg;

  localparam logic [2:0] C1_NOP          = 3'd0;
  localparam logic [2:0] C1_READ8        = 3'd1;
  localparam logic [2:0] C1_READ16       = 3'd2;
  localparam logic [2:0] C1_READ32       = 3'd3;
  localparam logic [2:0] C1_INV_LINE     = 3'd4;
  localparam logic [2:0] C1_WRITE8       = 3'd5;
  localparam logic [2:0] C1_WRITE16      = 3'd6;
  localparam logic [2:0] C1_WRITE32      = 3'd7;
  // The cache answers every transaction with the same code as WRITE32.
  localparam logic [2:0] C1_WRITE32_RESP = 3'd7;

  typedef enum logic [2:0] {
    C1_ST_IDLE  = 3'd0,
    C1_ST_SEND0 = 3'd1,
    C1_ST_SEND1 = 3'd2,
    C1_ST_TURN  = 3'd3,
    C1_ST_WAIT  = 3'd4,
    C1_ST_RECV1 = 3'd5,
    C1_ST_DONE  = 3'd6
  } c1_state_e;

  function automatic logic is_write(input logic [2:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  function automatic logic is_read(input logic [2:0] cmd);
    return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
  endfunction

endpackage

// File: rtl/c1_wait_timer.sv
// Response-wait counter: cleared before WAIT, advances on each idle WAIT cycle.
// o_expired flags the last allowed cycle; TIMEOUT=0 removes the counter entirely.
module c1_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

      logic [W-1:0] r_count;

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of its neighbours.
      always_ff @(posedge clk) begin
        if (reset || i_clear) begin
          r_count <= '0;
        end else if (i_enable) begin
          r_count <= r_count + W'(1);
        end
      end

      assign o_expired = (r_count == LAST);
    end
  endgenerate

endmodule

// File: rtl/c1_cpu_master.sv
// CPU-side C1 bus master: takes one request over valid/ready, runs the two-beat
// command phase, turns the shared lines around and collects the cache response.
module c1_cpu_master
  import c1_bus_pkg::*;
#(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int TIMEOUT           = 64
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       req_valid,
  output logic                                       req_ready,
  input  logic [2:0]                                 req_cmd,
  input  logic [MEM_ADDR_SIZE-1:0]                   req_addr,
  input  logic [2*BUS_SIZE-1:0]                      req_wdata,
  output logic                                       resp_valid,
  output logic [2*BUS_SIZE-1:0]                      resp_rdata,
  output logic                                       resp_err,
  output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
  inout  wire  [BUS_SIZE-1:0]                        data,
  inout  wire  [2:0]                                 command
);

  localparam int ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int DATA_W = 2 * BUS_SIZE;

  localparam logic [2:0] ST_IDLE  = C1_ST_IDLE;
  localparam logic [2:0] ST_SEND0 = C1_ST_SEND0;
  localparam logic [2:0] ST_SEND1 = C1_ST_SEND1;
  localparam logic [2:0] ST_TURN  = C1_ST_TURN;
  localparam logic [2:0] ST_WAIT  = C1_ST_WAIT;
  localparam logic [2:0] ST_RECV1 = C1_ST_RECV1;
  localparam logic [2:0] ST_DONE  = C1_ST_DONE;

  logic [2:0]               r_state;
  logic [2:0]               r_cmd;
  logic [MEM_ADDR_SIZE-1:0] r_addr;
  logic [DATA_W-1:0]        r_wdata;
  logic [DATA_W-1:0]        r_rdata;
  logic                     r_err;

  logic                     w_resp_seen;
  logic                     w_expired;
  logic                     w_cmd_oe;
  logic                     w_data_oe;
  logic [BUS_SIZE-1:0]      w_data_out;
  logic [ADDR_W-1:0]        w_addr_out;

  // Case equality keeps an undriven or unknown command from counting as a response.
  assign w_resp_seen = (r_state == ST_WAIT) && (command === C1_WRITE32_RESP);

  c1_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (r_state == ST_TURN),
    .i_enable  ((r_state == ST_WAIT) && !w_resp_seen),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cmd   <= C1_NOP;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cmd   <= req_cmd;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= (req_cmd == C1_NOP);
            r_state <= (req_cmd == C1_NOP) ? ST_DONE : ST_SEND0;
          end
        end
        ST_SEND0: r_state <= ST_SEND1;
        ST_SEND1: r_state <= ST_TURN;
        ST_TURN:  r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_resp_seen) begin
            case (r_cmd)
              C1_READ8:  r_rdata <= DATA_W'(data[7:0]);
              C1_READ16: r_rdata <= DATA_W'(data);
              C1_READ32: r_rdata[BUS_SIZE-1:0] <= data;
              default:   ;
            endcase
            r_state <= (r_cmd == C1_READ32) ? ST_RECV1 : ST_DONE;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= ST_DONE;
          end
        end
        ST_RECV1: begin
          r_rdata[DATA_W-1:BUS_SIZE] <= data;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_cmd_oe   = 1'b0;
    w_data_oe  = 1'b0;
    w_data_out = '0;
    w_addr_out = '0;
    case (r_state)
      ST_SEND0: begin
        w_cmd_oe   = 1'b1;
        w_addr_out = r_addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
        w_data_oe  = is_write(r_cmd);
        w_data_out = r_wdata[BUS_SIZE-1:0];
      end
      ST_SEND1: begin
        w_cmd_oe   = 1'b1;
        w_addr_out = ADDR_W'(r_addr[CACHE_OFFSET_SIZE-1:0]);
        w_data_oe  = is_write(r_cmd);
        w_data_out = (r_cmd == C1_WRITE32) ? r_wdata[DATA_W-1:BUS_SIZE]
                                           : r_wdata[BUS_SIZE-1:0];
      end
      default: ;
    endcase
  end

  assign command    = w_cmd_oe  ? r_cmd      : 'z;
  assign data       = w_data_oe ? w_data_out : 'z;
  assign address    = w_addr_out;
  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_DONE);
  assign resp_err   = (r_state == ST_DONE) && r_err;
  assign resp_rdata = r_rdata;

endmodule
